// File: rtl/booth_ctrl_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier controller.
package booth_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EVAL,
    SHIFT,
    DONE
  } boothState_e;

  // aBarS encodings
  localparam logic BOOTH_ADD = 1'b0;
  localparam logic BOOTH_SUB = 1'b1;

  // {Y[0], Y-1} pair codes
  localparam logic [1:0] PAIR_NOP0 = 2'b00;
  localparam logic [1:0] PAIR_ADD  = 2'b01;
  localparam logic [1:0] PAIR_SUB  = 2'b10;
  localparam logic [1:0] PAIR_NOP1 = 2'b11;

  // A pair of equal bits needs no add/subtract, only the shift
  function automatic logic isNopPair(input logic [1:0] pair);
    return (pair == PAIR_NOP0) || (pair == PAIR_NOP1);
  endfunction

endpackage

// File: rtl/booth_down_counter.sv
// Parametrised loadable down-counter for the Booth shift count.
// A decrement requested at zero is ignored, so the count never wraps.
module booth_down_counter #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             dec,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] cnt,
  output logic             zero
);

  // Count register: load has priority over decrement
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (ld) begin
      cnt <= par_in;
    end else if (dec && !zero) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/booth_controller_n.sv
// Radix-2 Booth multiplier controller, WIDTH-bit signed operands.
// Optional feature: define BOOTH_SKIP_EN to perform the shift of a 00/11
// bit pair directly in EVAL, bypassing the SHIFT state.
module booth_controller_n
  import booth_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [1:0]                 Y0YminusOne,
  output logic                       done,
  output logic                       busy,
  output logic [$clog2(WIDTH)-1:0]   cnt,
  output logic                       ldX,
  output logic                       ldY,
  output logic                       initA,
  output logic                       initYminusOne,
  output logic                       ldA,
  output logic                       aBarS,
  output logic                       shRA,
  output logic                       shRY,
  output logic                       ldYminusOne
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  boothState_e state, nextState;
  logic        cntLd;
  logic        cntDec;
  logic        cntZero;

  booth_down_counter #(
    .WIDTH(CW)
  ) uShiftCnt (
    .clk   (clk),
    .rst   (rst),
    .ld    (cntLd),
    .dec   (cntDec),
    .par_in(CNT_INIT),
    .cnt   (cnt),
    .zero  (cntZero)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state, counter control and datapath control decode
  always_comb begin
    nextState     = state;
    cntLd         = 1'b0;
    cntDec        = 1'b0;
    done          = 1'b0;
    ldX           = 1'b0;
    ldY           = 1'b0;
    initA         = 1'b0;
    initYminusOne = 1'b0;
    ldA           = 1'b0;
    aBarS         = BOOTH_ADD;
    shRA          = 1'b0;
    shRY          = 1'b0;
    ldYminusOne   = 1'b0;

    case (state)
      IDLE: begin
        if (start) nextState = LOAD;
      end

      LOAD: begin
        ldX           = 1'b1;
        ldY           = 1'b1;
        initA         = 1'b1;
        initYminusOne = 1'b1;
        cntLd         = 1'b1;
        nextState     = EVAL;
      end

      EVAL: begin
        if (isNopPair(Y0YminusOne)) begin
`ifdef BOOTH_SKIP_EN
          shRA        = 1'b1;
          shRY        = 1'b1;
          ldYminusOne = 1'b1;
          cntDec      = 1'b1;
          nextState   = cntZero ? DONE : EVAL;
`else
          nextState   = SHIFT;
`endif
        end else begin
          ldA       = 1'b1;
          aBarS     = (Y0YminusOne == PAIR_SUB) ? BOOTH_SUB : BOOTH_ADD;
          nextState = SHIFT;
        end
      end

      SHIFT: begin
        shRA        = 1'b1;
        shRY        = 1'b1;
        ldYminusOne = 1'b1;
        cntDec      = 1'b1;
        nextState   = cntZero ? DONE : EVAL;
      end

      DONE: begin
        done      = 1'b1;
        nextState = IDLE;
      end

      default: nextState = IDLE;
    endcase

    // Abort overrides every transition and freezes the counter; the
    // controls of the current state still decode for this cycle.
    if (abort && (state != IDLE)) begin
      nextState = IDLE;
      cntLd     = 1'b0;
      cntDec    = 1'b0;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_booth_controller_n.sv
// Self-checking bench for booth_controller_n: a behavioural A/X/Y/Y-1
// datapath driven by the controller, arithmetic product and latency
// expectations queued at issue time and checked on each done pulse.
module tb_booth_controller_n;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [1:0]    y0Ym1;
  logic          done, busy;
  logic [CW-1:0] cnt;
  logic          ldX, ldY, initA, initYminusOne, ldA, aBarS;
  logic          shRA, shRY, ldYminusOne;

  always #5 clk = ~clk;

  booth_controller_n #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .Y0YminusOne  (y0Ym1),
    .done         (done),
    .busy         (busy),
    .cnt          (cnt),
    .ldX          (ldX),
    .ldY          (ldY),
    .initA        (initA),
    .initYminusOne(initYminusOne),
    .ldA          (ldA),
    .aBarS        (aBarS),
    .shRA         (shRA),
    .shRY         (shRY),
    .ldYminusOne  (ldYminusOne)
  );

  // Behavioural datapath: A is one bit wider so A-X cannot overflow
  logic signed [W:0]   regA   = '0;
  logic [W-1:0]        regX   = '0;
  logic [W-1:0]        regY   = '0;
  logic                regYm1 = 1'b0;
  logic [W-1:0]        xOp    = '0;
  logic [W-1:0]        yOp    = '0;
  logic signed [W:0]   xExt;
  logic signed [W:0]   aSum;
  logic [2*W:0]        shifted;
  logic [2*W-1:0]      product;

  assign y0Ym1   = {regY[0], regYm1};
  assign xExt    = {regX[W-1], regX};
  assign product = {regA[W-1:0], regY};

  always_comb begin
    aSum    = ldA ? (aBarS ? regA - xExt : regA + xExt) : regA;
    shifted = $signed({aSum, regY}) >>> 1;
  end

  always @(posedge clk) begin
    if (ldX) regX <= xOp;
    if (initA) regA <= '0;
    else if (shRA) regA <= shifted[2*W:W];
    else if (ldA) regA <= aSum;
    if (ldY) regY <= yOp;
    else if (shRY) regY <= shifted[W-1:0];
    if (initYminusOne) regYm1 <= 1'b0;
    else if (ldYminusOne) regYm1 <= regY[0];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2*W-1:0] prod;
    int             lat;
  } exp_t;
  exp_t sbq[$];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Cycles from start sample to done, from the pair-by-pair rules
  function automatic int expLatency(input logic [W-1:0] y);
    int   lat;
    logic prev;
    lat  = 2;
    prev = 1'b0;
    for (int i = 0; i < int'(W); i++) begin
`ifdef BOOTH_SKIP_EN
      lat += (y[i] == prev) ? 1 : 2;
`else
      lat += 2;
`endif
      prev = y[i];
    end
    return lat;
  endfunction

  function automatic exp_t mkExp(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    logic signed [2*W-1:0] p;
    p      = $signed(x) * $signed(y);
    e.prod = p;
    e.lat  = expLatency(y);
    return e;
  endfunction

  // Monitor: protocol rules every cycle, scoreboard pop on done
  initial begin
    int   startCyc;
    logic prevLoad;
    exp_t e;
    startCyc = 0;
    prevLoad = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (!busy && start) startCyc = cyc;
        if (prevLoad) chk("cnt_reload", 64'(cnt), 64'(W - 1));
        prevLoad = ldX;
        if (ldA) chk("ldA_shift_overlap", 64'(shRA), 64'd0);
        if (!busy)
          chk("idle_ctrl", 64'({done, ldX, ldY, initA, initYminusOne, ldA, aBarS,
                               shRA, shRY, ldYminusOne}), 64'd0);
        if (shRA || shRY || ldYminusOne)
          chk("shift_group", 64'({shRA, shRY, ldYminusOne}), 64'b111);
        if (ldX || ldY || initA || initYminusOne)
          chk("load_group", 64'({ldX, ldY, initA, initYminusOne}), 64'b1111);
        if (done) begin
          if (sbq.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
          end else begin
            e = sbq.pop_front();
            chk("product", 64'(product), 64'(e.prod));
            chk("latency", 64'(cyc - startCyc), 64'(e.lat));
          end
        end
      end else begin
        prevLoad = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic startOp(input logic [W-1:0] x, input logic [W-1:0] y, input bit doPush);
    xOp = x;
    yOp = y;
    if (doPush) sbq.push_back(mkExp(x, y));
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic waitDone(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < int'(4 * W + 8) && !seen; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    chk("done_seen", 64'(seen), 64'd1);
  endtask

  logic [W-1:0] dirX [8] = '{8'h05, 8'hFD, 8'h80, 8'h7F, 8'h80, 8'hFF, 8'h00, 8'h5A};
  logic [W-1:0] dirY [8] = '{8'h00, 8'hFF, 8'h80, 8'h80, 8'h7F, 8'h55, 8'h33, 8'h01};

  initial begin
    bit seen;
    bit sawDone;
    int nShift;
    rst   = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    tick();
    tick();
    chk("reset_outputs", 64'({done, busy, ldX, ldY, initA, initYminusOne, ldA, aBarS,
                             shRA, shRY, ldYminusOne}), 64'd0);
    chk("reset_cnt", 64'(cnt), 64'd0);
    rst = 1'b1;
    tick();

    // Directed corner operands, then random ones
    for (int i = 0; i < 8; i++) begin
      startOp(dirX[i], dirY[i], 1'b1);
      waitDone(seen);
      tick();
    end
    for (int i = 0; i < 40; i++) begin
      startOp(W'($urandom), W'($urandom), 1'b1);
      waitDone(seen);
      tick();
      repeat ($urandom_range(0, 2)) tick();
    end

    // Abort in cycle 5, restart in cycle 7
    startOp(8'h12, 8'h34, 1'b0);
    sawDone = 1'b0;
    repeat (4) begin
      tick();
      sawDone |= done;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", 64'({busy, done, sawDone}), 64'd0);
    tick();
    startOp(8'hC3, 8'h96, 1'b1);
    chk("restart_load", 64'(ldX), 64'd1);
    waitDone(seen);
    tick();

    // Asynchronous reset mid-shift, no done afterwards
    startOp(8'h21, 8'h00, 1'b0);
    nShift = 0;
    for (int i = 0; i < int'(4 * W) && nShift < 3; i++) begin
      tick();
      if (shRA) nShift++;
    end
    chk("reached_shift", 64'(nShift), 64'd3);
    #2 rst = 1'b0;
    #1;
    chk("async_reset", 64'({done, busy, ldX, ldY, initA, initYminusOne, ldA, aBarS,
                           shRA, shRY, ldYminusOne}), 64'd0);
    chk("async_reset_cnt", 64'(cnt), 64'd0);
    tick();
    rst = 1'b1;
    sawDone = 1'b0;
    repeat (3 * W) begin
      tick();
      sawDone |= done | busy;
    end
    chk("no_done_after_reset", 64'(sawDone), 64'd0);

    // Start held high: back-to-back operations with one IDLE cycle between
    xOp = 8'hE7;
    yOp = 8'h3C;
    sbq.push_back(mkExp(xOp, yOp));
    sbq.push_back(mkExp(xOp, yOp));
    start = 1'b1;
    waitDone(seen);
    tick();
    chk("b2b_idle", 64'(busy), 64'd0);
    tick();
    chk("b2b_load", 64'({busy, ldX}), 64'b11);
    start = 1'b0;
    waitDone(seen);
    tick();

    repeat (4) tick();
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/booth_controller_n.md
# booth_controller_n

Parametrised radix-2 Booth multiplier controller that sequences a WIDTH-bit signed multiply over the shared A/X/Y/Y-1 datapath. It is the next-generation replacement for the fixed-width multiplier controller. It adds a width parameter, an internal down-counter sized from WIDTH, an abort request, a busy flag and an optional same-cycle skip for 00/11 bit pairs. It sits between the system start/done handshake and the multiplier datapath register/ALU controls.

## Interface
- WIDTH, 8, operand width in bits; legal range is 2 or more.
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a multiply; sampled only in IDLE.
- abort  in  1  synchronous cancel; honoured in any state except IDLE.
- Y0YminusOne  in  2  {Y[0], Y-1} from the datapath.
- done  out  1  single-cycle completion pulse.
- busy  out  1  high in every state except IDLE.
- cnt  out  $clog2(WIDTH)  remaining shifts minus one; debug only.
- ldX, ldY  out  1  load multiplicand and multiplier registers.
- initA  out  1  clear accumulator A.
- initYminusOne  out  1  clear the Y-1 flop.
- ldA  out  1  A <= A ± X.
- aBarS  out  1  0 selects add, 1 selects subtract; meaningful only when ldA=1.
- shRA, shRY  out  1  arithmetic shift right of the {A,Y} pair.
- ldYminusOne  out  1  Y-1 <= Y[0], asserted in the same cycle as the shift.

## Operation
- States are IDLE, LOAD, EVAL, SHIFT and DONE.
- **IDLE**
  - All control outputs are 0.
  - If start=1, go to LOAD.
- **LOAD**
  - Assert ldX, ldY, initA and initYminusOne.
  - Load the counter with WIDTH-1.
  - Go to EVAL.
- **EVAL**
  - Y0YminusOne=01: assert ldA with aBarS=0.
  - Y0YminusOne=10: assert ldA with aBarS=1.
  - Y0YminusOne=00 or 11: ldA=0.
  - Go to SHIFT.
- **SHIFT**
  - Assert shRA, shRY and ldYminusOne.
  - If cnt==0, go to DONE; otherwise decrement cnt and go to EVAL.
- **DONE**
  - Assert done for one cycle, then go to IDLE.
- **Abort**
  - abort=1 in LOAD, EVAL, SHIFT or DONE forces IDLE on the next edge.
  - done is not asserted unless the state was already DONE.
  - abort has priority over every other transition.
- **Start rules**
  - start while busy is ignored.
  - start held high continuously produces back-to-back operations separated by exactly one IDLE cycle.
- **Outputs**
  - Controls are decoded combinationally from state.
  - In EVAL they also depend on Y0YminusOne.
- **Counter**
  - Unsigned, $clog2(WIDTH) bits.
  - Never wraps, because a decrement at 0 is suppressed.

## Timing
- Reset value: state IDLE, cnt=0, all outputs 0 including done and busy.
- Reset is honoured mid-operation with the same values; no done pulse follows.
- Let cycle 0 be the IDLE cycle in which start is sampled.
- Without skip: LOAD in cycle 1, EVAL/SHIFT pairs in cycles 2..2·WIDTH+1, done in cycle 2·WIDTH+2.
- Product is valid in the datapath from the cycle done is high.

## Configuration
- Macro: BOOTH_SKIP_EN.
- **Defined:** in EVAL with Y0YminusOne of 00 or 11, the shift actions are asserted in EVAL itself.
  - Asserted actions: shRA, shRY, ldYminusOne and the counter decrement.
  - SHIFT is bypassed: next state is EVAL, or DONE if cnt==0.
  - 01 and 10 still take EVAL then SHIFT.
  - Latency is between WIDTH+2 and 2·WIDTH+2.
- **Undefined:** every bit takes EVAL then SHIFT, giving a fixed latency of 2·WIDTH+2.

## Structure
- **Package booth_ctrl_pkg**
  - State enum.
  - Constants BOOTH_ADD=1'b0 and BOOTH_SUB=1'b1 for aBarS.
  - Y-pair codes PAIR_NOP0=2'b00, PAIR_ADD=2'b01, PAIR_SUB=2'b10, PAIR_NOP1=2'b11.
- **Sub-module booth_down_counter**
  - Parametrised width; ports clk, rst, ld, dec, par_in, cnt, zero.
  - Generalises the existing 3-bit counter.
- Top-level holds the FSM and output decode.

## Test plan
- WIDTH=8, macro off, Y0YminusOne held 00, start pulsed in cycle 0 -> ldA never asserted, 8 SHIFT cycles, done only in cycle 18, busy high in cycles 1..18.
- WIDTH=8, macro on, Y0YminusOne held 00 -> shifts in cycles 2..9, done in cycle 10; with 01 held instead -> done in cycle 18.
- Y0YminusOne=10 in first EVAL, then 01 -> ldA=1 with aBarS=1, then ldA=1 with aBarS=0; shRA never coincides with ldA when the macro is off.
- abort=1 in cycle 5 -> IDLE in cycle 6, busy=0, no done; a new start in cycle 7 -> LOAD in cycle 8 with cnt reloaded to 7.
- rst low for 1 cycle mid-SHIFT -> all outputs 0 immediately; no done after release.
- WIDTH=2, start held high -> done in cycle 6, one IDLE cycle, LOAD again; cnt sequence 1,0 and no decrement below 0.
